// File: rtl/ctrl_id_pipe.sv
// Decode stage between fetch and execute: valid/ready handshakes on both sides,
// flush, illegal-opcode flagging and a sequencer that stalls fetch after load/store.
module ctrl_id_pipe #(
  parameter int IR_W       = 16,
  parameter int MEM_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  input  logic [IR_W-1:0] i_ir,
  output logic            o_ready,
  input  logic            i_ex_ready,
  input  logic            i_flush,
  output logic            o_valid_r,
  output logic [IR_W-1:0] o_ir_ex_r,
  output logic [2:0]      o_alu_sel_r,
  output logic [3:0]      o_mem_data_access_r,
  output logic            o_illegal_r,
  output logic            o_mem_busy,
  output logic            o_dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high in the cycle before it; ready never depends on valid on the same side.

  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_SUB    = 3'b101;
  localparam logic [2:0] ALU_MV_IMM = 3'b001;
  localparam logic [2:0] ALU_MV_REG = 3'b010;
  localparam logic [3:0] MEM_CNT    = MEM_CYCLES[3:0];

  typedef enum logic {
    S_RUN      = 1'b0,
    S_MEM_WAIT = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic [8:0] op_hi;
  logic [2:0] dec_alu;
  logic       dec_mem;
  logic       dec_ill;
  logic       accept;
  logic       consume;

  assign op_hi = i_ir[IR_W-1 -: 9];

  // Decode table keyed on OP[15:7]; encodings match the existing EX select codes.
  always_comb begin
    dec_alu = ALU_MV_IMM;
    dec_mem = 1'b0;
    dec_ill = 1'b0;
    casez (op_hi)
      9'b0001110??: dec_alu = ALU_ADD;
      9'b101100001: dec_alu = ALU_SUB;
      9'b00100????: dec_alu = ALU_MV_IMM;
      9'b01000110?: dec_alu = ALU_MV_REG;
      9'b01101????: begin
        dec_alu = ALU_ADD;
        dec_mem = 1'b1;
      end
      9'b01001????: begin
        dec_alu = ALU_ADD;
        dec_mem = 1'b1;
      end
      9'b01100????: begin
        dec_alu = ALU_ADD;
        dec_mem = 1'b1;
      end
      9'b11100????: dec_alu = ALU_ADD;
      9'b1101?????: dec_alu = ALU_ADD;
      9'b00101????: dec_alu = ALU_SUB;
      default: begin
        dec_alu = ALU_MV_IMM;
        dec_ill = 1'b1;
      end
    endcase
  end

  assign accept  = i_valid & o_ready;
  assign consume = o_valid_r & i_ex_ready & ~accept;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // FSM next-state: flush wins over everything, cnt is zero whenever in RUN
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (i_flush) begin
      state_nxt = S_RUN;
      cnt_nxt   = 4'd0;
    end else begin
      case (state)
        S_RUN: begin
          if (accept && dec_mem) begin
            state_nxt = S_MEM_WAIT;
            cnt_nxt   = MEM_CNT;
          end
        end
        S_MEM_WAIT: begin
          if (cnt == 4'd1) begin
            state_nxt = S_RUN;
            cnt_nxt   = 4'd0;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end
        default: begin
          state_nxt = S_RUN;
          cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    o_mem_busy  = (state == S_MEM_WAIT);
    o_ready     = (state == S_RUN) & (~o_valid_r | i_ex_ready) & ~i_flush;
    o_dbg_state = state;
  end

  // Output registers toward EX
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_valid_r           <= 1'b0;
      o_ir_ex_r           <= '0;
      o_alu_sel_r         <= ALU_MV_IMM;
      o_mem_data_access_r <= 4'd0;
      o_illegal_r         <= 1'b0;
    end else if (i_flush) begin
      o_valid_r           <= 1'b0;
      o_ir_ex_r           <= '0;
      o_alu_sel_r         <= ALU_MV_IMM;
      o_mem_data_access_r <= 4'd0;
      o_illegal_r         <= 1'b0;
    end else if (accept) begin
      o_valid_r           <= 1'b1;
      o_ir_ex_r           <= i_ir;
      o_alu_sel_r         <= dec_alu;
      o_mem_data_access_r <= dec_mem ? MEM_CNT : 4'd0;
      o_illegal_r         <= dec_ill;
    end else if (consume) begin
      o_valid_r <= 1'b0;
    end
  end

  a_cnt_nonzero_in_wait : assert property (@(posedge clk) disable iff (!rst)
    (state == S_MEM_WAIT) |-> (cnt != 4'd0));
  a_cnt_zero_in_run : assert property (@(posedge clk) disable iff (!rst)
    (state == S_RUN) |-> (cnt == 4'd0));

endmodule

// File: tb/tb_ctrl_id_pipe.sv
// Randomized bench for ctrl_id_pipe with a table-driven reference model and a
// scoreboard queue of expected decoded outputs.
module tb_ctrl_id_pipe;

  localparam int IR_W       = 32;
  localparam int MEM_CYCLES = 3;
  localparam int EW         = IR_W + 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            i_valid = 1'b0;
  logic [IR_W-1:0] i_ir = '0;
  logic            o_ready;
  logic            i_ex_ready = 1'b0;
  logic            i_flush = 1'b0;
  logic            o_valid_r;
  logic [IR_W-1:0] o_ir_ex_r;
  logic [2:0]      o_alu_sel_r;
  logic [3:0]      o_mem_data_access_r;
  logic            o_illegal_r;
  logic            o_mem_busy;
  logic            o_dbg_state;

  ctrl_id_pipe #(.IR_W(IR_W), .MEM_CYCLES(MEM_CYCLES)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ir(i_ir), .o_ready(o_ready),
    .i_ex_ready(i_ex_ready), .i_flush(i_flush), .o_valid_r(o_valid_r),
    .o_ir_ex_r(o_ir_ex_r), .o_alu_sel_r(o_alu_sel_r),
    .o_mem_data_access_r(o_mem_data_access_r), .o_illegal_r(o_illegal_r),
    .o_mem_busy(o_mem_busy), .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  logic [EW-1:0] exp_q[$];

  // reference model state
  bit m_valid   = 1'b0;
  int m_wait    = 0;
  bit m_cleared = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decode rules as match/mask pairs, first hit wins.
  function automatic logic [EW-1:0] ref_decode(input logic [IR_W-1:0] ir);
    logic [8:0] match [10];
    logic [8:0] mask  [10];
    logic [2:0] alu   [10];
    bit         mem   [10];
    logic [8:0] op;
    match = '{9'b000111000, 9'b101100001, 9'b001000000, 9'b010001100, 9'b011010000,
              9'b010010000, 9'b011000000, 9'b111000000, 9'b110100000, 9'b001010000};
    mask  = '{9'b111111100, 9'b111111111, 9'b111110000, 9'b111111110, 9'b111110000,
              9'b111110000, 9'b111110000, 9'b111110000, 9'b111100000, 9'b111110000};
    alu   = '{3'b000, 3'b101, 3'b001, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b101};
    mem   = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0};
    op = ir[IR_W-1 -: 9];
    for (int k = 0; k < 10; k++) begin
      if ((op & mask[k]) == match[k])
        return {ir, alu[k], (mem[k] ? 4'(MEM_CYCLES) : 4'd0), 1'b0};
    end
    return {ir, 3'b001, 4'd0, 1'b1};
  endfunction

  function automatic bit is_mem(input logic [IR_W-1:0] ir);
    logic [EW-1:0] d;
    d = ref_decode(ir);
    return d[4:1] != 4'd0;
  endfunction

  function automatic bit model_ready(input bit exr, input bit fl);
    return (m_wait == 0) && (!m_valid || exr) && !fl;
  endfunction

  task automatic model_reset();
    m_valid   = 1'b0;
    m_wait    = 0;
    m_cleared = 1'b1;
    exp_q.delete();
  endtask

  // Advance the model across one rising edge with the inputs that were applied.
  task automatic model_update(input bit v, input logic [IR_W-1:0] ir, input bit exr, input bit fl);
    bit acc;
    acc = v && model_ready(exr, fl);
    if (fl) begin
      if (m_valid && !exr && exp_q.size() > 0) void'(exp_q.pop_back());
      m_valid   = 1'b0;
      m_wait    = 0;
      m_cleared = 1'b1;
    end else if (acc) begin
      exp_q.push_back(ref_decode(ir));
      m_valid   = 1'b1;
      m_cleared = 1'b0;
      m_wait    = is_mem(ir) ? MEM_CYCLES : 0;
    end else begin
      if (m_valid && exr) m_valid = 1'b0;
      if (m_wait > 0) m_wait--;
    end
  endtask

  // driver: one cycle of stimulus, entered and left just after a rising edge
  task automatic step(input bit v, input logic [IR_W-1:0] ir, input bit exr, input bit fl);
    i_valid    = v;
    i_ir       = ir;
    i_ex_ready = exr;
    i_flush    = fl;
    @(posedge clk);
    model_update(v, ir, exr, fl);
    #1;
  endtask

  function automatic logic [IR_W-1:0] mk(input logic [15:0] op);
    return {op, 16'($urandom)};
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      chk("o_ready", 64'(o_ready), 64'(model_ready(i_ex_ready, i_flush)));
      chk("o_mem_busy", 64'(o_mem_busy), 64'(m_wait > 0));
      chk("dbg_state", 64'(o_dbg_state), 64'(m_wait > 0));
      chk("o_valid_r", 64'(o_valid_r), 64'(m_valid));
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          chk("exp_q_nonempty", 64'(0), 64'(1));
        end else begin
          chk("decoded", 64'({o_ir_ex_r, o_alu_sel_r, o_mem_data_access_r, o_illegal_r}),
              64'(exp_q[0]));
          if (i_ex_ready) void'(exp_q.pop_front());
        end
      end else if (m_cleared) begin
        chk("cleared", 64'({o_ir_ex_r, o_alu_sel_r, o_mem_data_access_r, o_illegal_r}),
            64'({32'h0, 3'b001, 4'd0, 1'b0}));
      end
    end
  end

  logic [15:0] ops [12] = '{16'h1C48, 16'h2105, 16'h4608, 16'h2A03, 16'h6808, 16'h6008,
                            16'h4801, 16'hB081, 16'hE000, 16'hD001, 16'hFFFF, 16'h2001};

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(o_valid_r), 64'(0));
    chk("rst_alu", 64'(o_alu_sel_r), 64'(3'b001));
    chk("rst_mem", 64'(o_mem_data_access_r), 64'(0));
    chk("rst_busy", 64'(o_mem_busy), 64'(0));
    chk("rst_ir", 64'(o_ir_ex_r), 64'(0));
    rst    = 1'b1;
    mon_en = 1'b1;

    // stream ADD, MOV, MOV reg, CMP
    step(1, mk(16'h1C48), 1, 0);
    step(1, mk(16'h2105), 1, 0);
    step(1, mk(16'h4608), 1, 0);
    step(1, mk(16'h2A03), 1, 0);
    step(0, '0, 1, 0);

    // LDR followed by a held MOV
    step(1, mk(16'h6808), 1, 0);
    repeat (5) step(1, {16'h2001, 16'h0000}, 1, 0);
    step(0, '0, 1, 0);

    // backpressure
    step(1, mk(16'h2105), 1, 0);
    repeat (5) step(1, mk(16'h1C48), 0, 0);
    step(1, mk(16'h1C48), 1, 0);
    step(0, '0, 1, 0);

    // flush in MEM_WAIT with a STR presented
    step(1, mk(16'h6808), 1, 0);
    step(1, mk(16'h6008), 1, 1);
    step(1, mk(16'h2001), 1, 0);
    step(0, '0, 1, 0);

    // illegal with full 32-bit pass-through
    step(1, 32'hFFFF_1234, 1, 0);
    step(0, '0, 1, 0);

    // asynchronous reset in the middle of MEM_WAIT
    step(1, mk(16'h6808), 1, 0);
    step(0, '0, 1, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 64'(o_valid_r), 64'(0));
    chk("arst_alu", 64'(o_alu_sel_r), 64'(3'b001));
    chk("arst_mem", 64'(o_mem_data_access_r), 64'(0));
    chk("arst_busy", 64'(o_mem_busy), 64'(0));
    model_reset();
    i_valid = 1'b1;
    i_ir    = mk(16'h2001);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    step(1, mk(16'h2001), 1, 0);
    step(0, '0, 1, 0);

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      logic [IR_W-1:0] ir;
      if ($urandom_range(0, 1) == 0) ir = mk(ops[$urandom_range(0, 11)]);
      else ir = IR_W'($urandom);
      step($urandom_range(0, 9) < 7, ir, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    end

    repeat (MEM_CYCLES + 3) step(0, '0, 1, 0);
    mon_en = 1'b0;
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_id_pipe.md
# ctrl_id_pipe

Parametrised decode stage for the Thumb-subset pipeline, placed between fetch (IF) and execute (EX). It adds valid/ready handshakes on both sides, a pipeline flush, illegal-opcode flagging and an internal memory-wait sequencer. The sequencer holds fetch for a configurable number of cycles after each load/store. The decode table matches the established ALU select encoding, so EX needs no change.

## Interface
- IR_W, 16, instruction register width. Must be ≥16. The opcode field is the top 16 bits, `i_ir[IR_W-1 -: 16]`, called OP below.
- MEM_CYCLES, 2, memory-wait length in cycles, legal range 1..15.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_valid  in  1  IF presents an instruction.
- i_ir  in  IR_W  instruction from IF.
- o_ready  out  1  decode accepts from IF this cycle (combinational).
- i_ex_ready  in  1  EX consumes the current output this cycle.
- i_flush  in  1  branch taken; discard in-flight state.
- o_valid_r  out  1  output registers hold a valid decoded instruction.
- o_ir_ex_r  out  IR_W  instruction forwarded to EX.
- o_alu_sel_r  out  3  ALU select.
- o_mem_data_access_r  out  4  memory-access cycle count for EX; 0 means no memory access.
- o_illegal_r  out  1  decoded instruction is not in the table.
- o_mem_busy  out  1  sequencer is in MEM_WAIT (combinational from state).

## Operation
- ALU codes: ADD=000, SUB=101, MV_IMM=001, MV_REG=010.
- Decode table on OP[15:7]:
  - 0001110?? ADD → ADD
  - 101100001 SUB SP → SUB
  - 00100???? MOV imm → MV_IMM
  - 01000110? MOV reg → MV_REG
  - 01101???? LDR → ADD, mem
  - 01001???? LDR literal → ADD, mem
  - 01100???? STR → ADD, mem
  - 11100???? B → ADD
  - 1101????? B<c> → ADD
  - 00101???? CMP → SUB
  - Anything else → MV_IMM, illegal.
- Accept = i_valid & o_ready.
- o_ready = (state==RUN) & (!o_valid_r | i_ex_ready) & !i_flush.
- On accept, the output registers load:
  - o_ir_ex_r ← i_ir
  - o_alu_sel_r ← table value
  - o_illegal_r ← illegal
  - o_mem_data_access_r ← MEM_CYCLES for mem ops, else 0
  - o_valid_r ← 1
- Consume without accept (o_valid_r & i_ex_ready & !accept): o_valid_r ← 0. The other outputs hold their values.
- No accept and no consume: all outputs hold.
- FSM states:
  - RUN: an accepted mem op loads cnt ← MEM_CYCLES and moves to MEM_WAIT.
  - MEM_WAIT: cnt decrements every cycle. When cnt==1 the state returns to RUN on the next edge. o_ready is 0 throughout.
  - cnt is 4 bits and never wraps; it is 0 in RUN.
- Flush (highest priority), on the edge where i_flush=1:
  - o_valid_r←0, o_ir_ex_r←0, o_alu_sel_r←MV_IMM, o_mem_data_access_r←0, o_illegal_r←0
  - state←RUN, cnt←0
  - An instruction presented in the same cycle is dropped, because o_ready is 0.
- Reset (rst=0, asynchronous, at any time including mid-MEM_WAIT) forces the same values as a flush. Release is synchronous to clk.

## Timing
- Decode latency: 1 cycle from accept edge to o_valid_r/o_alu_sel_r visible.
- Back-to-back non-mem instructions sustain 1 per cycle while i_ex_ready=1.
- Mem op accepted at edge N:
  - o_ready=0 for cycles N+1 .. N+MEM_CYCLES.
  - Next accept possible at edge N+MEM_CYCLES+1.
- Backpressure: if o_valid_r=1 and i_ex_ready=0, then o_ready=0 and the outputs are stable until consumed.
- o_mem_busy and o_ready are combinational from registered state and inputs. There is no combinational path from i_ir to any output.

## Test plan
- Reset: assert rst=0 mid-MEM_WAIT → immediately o_valid_r=0, o_alu_sel_r=001, o_mem_data_access_r=0, o_mem_busy=0; after release, o_ready=1 when i_valid=1.
- Stream with i_ex_ready=1: present 0x1C48 (ADD), 0x2105 (MOV), 0x4608 (MOV reg), 0x2A03 (CMP) → o_alu_sel_r 000, 001, 010, 101 on consecutive cycles, each one cycle after accept, o_mem_data_access_r=0.
- MEM_CYCLES=3: present 0x6808 (LDR) → o_mem_data_access_r=3, o_mem_busy=1 and o_ready=0 for 3 cycles; the following 0x2001 is accepted on the 4th cycle after the LDR.
- Backpressure: hold i_ex_ready=0 for 5 cycles with o_valid_r=1 → o_ready=0, o_ir_ex_r unchanged; release → next instruction loads one cycle later.
- Flush: assert i_flush in the same cycle as i_valid with 0x6008 (STR), while in MEM_WAIT → next cycle o_valid_r=0, state RUN, STR not issued.
- Illegal and width: with IR_W=32, present OP=0xFFFF → o_illegal_r=1, o_alu_sel_r=001, full 32-bit o_ir_ex_r passed through.
